// File: rtl/fire_anim_ctrl.sv
// fire_anim_ctrl: frame-locked fire sprite sequencer (off, ignite blink, burn, fade blink).
module fire_anim_ctrl #(
  parameter int FRAME_DIV = 8,
  parameter int BLINK_DIV = 4,
  parameter int IGNITE_FRAMES = 60,
  parameter int FADE_FRAMES = 45
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vs,
  input  logic       ignite,
  input  logic       extinguish,
  input  logic       pause,
  output logic       animation_state,
  output logic       isplay,
  output logic [1:0] fire_state,
  output logic       burning
);
  typedef enum logic [1:0] {OFF, IGNITE, BURN, FADE} state_t;
  localparam logic [7:0] FRAME_LAST = 8'(FRAME_DIV - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);
  localparam logic [7:0] IGNITE_LAST = 8'(IGNITE_FRAMES - 1);
  localparam logic [7:0] FADE_LAST = 8'(FADE_FRAMES - 1);
  state_t state;
  logic vs_q;
  logic [7:0] frame_cnt, blink_cnt, anim_cnt;
  logic tick;
  assign tick = vs & ~vs_q & ~pause;
  assign fire_state = state;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= OFF;
      vs_q <= 1'b1;
      frame_cnt <= '0;
      blink_cnt <= '0;
      anim_cnt <= '0;
      isplay <= 1'b0;
      animation_state <= 1'b0;
      burning <= 1'b0;
    end else begin
      vs_q <= vs;
      if ((state == OFF || state == FADE) && ignite) begin
        state <= IGNITE;
        isplay <= 1'b1;
        animation_state <= 1'b0;
        frame_cnt <= '0;
        blink_cnt <= '0;
        anim_cnt <= '0;
        burning <= 1'b0;
      end else if ((state == IGNITE || state == BURN) && extinguish) begin
        state <= FADE;
        isplay <= 1'b1;
        frame_cnt <= '0;
        blink_cnt <= '0;
        burning <= 1'b0;
      end else if (state != OFF && tick) begin
        anim_cnt <= (anim_cnt == FRAME_LAST) ? '0 : anim_cnt + 8'd1;
        animation_state <= animation_state ^ (anim_cnt == FRAME_LAST);
        if (state == IGNITE && frame_cnt == IGNITE_LAST) begin
          state <= BURN;
          isplay <= 1'b1;
          frame_cnt <= '0;
          blink_cnt <= '0;
          burning <= 1'b1;
        end else if (state == FADE && frame_cnt == FADE_LAST) begin
          state <= OFF;
          isplay <= 1'b0;
          animation_state <= 1'b0;
          frame_cnt <= '0;
          blink_cnt <= '0;
          anim_cnt <= '0;
        end else if (state != BURN) begin
          frame_cnt <= frame_cnt + 8'd1;
          blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 8'd1;
          isplay <= isplay ^ (blink_cnt == BLINK_LAST);
        end
      end
    end
  end
endmodule
